// File: rtl/clock_ctrl_pkg.sv
// Shared encodings, default divisors and small helpers for the clock_ctrl
// sequencing block and the display logic that decodes its mode.
package clock_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_SET_MIN  = 2'd1,
    ST_SET_HOUR = 2'd2,
    ST_ILLEGAL  = 2'd3
  } state_t;

  localparam int DEF_TICK_DIV  = 50_000_000;
  localparam int DEF_BLINK_DIV = 12_500_000;

  // Mode button walks RUN -> SET_MIN -> SET_HOUR -> RUN; the spare code recovers to RUN.
  function automatic state_t next_mode(input state_t s);
    case (s)
      ST_RUN:      next_mode = ST_SET_MIN;
      ST_SET_MIN:  next_mode = ST_SET_HOUR;
      default:     next_mode = ST_RUN;
    endcase
  endfunction

  function automatic int cnt_width(input int div);
    cnt_width = (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/clock_ctrl_btn_pulse.sv
// Button conditioner: two-flop synchronizer, history flop and rising-edge
// detect giving one single-cycle pulse per press however long it is held.
module btn_pulse (
  input  logic clk,
  input  logic rstn,
  input  logic btn,
  output logic pulse
);

  logic sync1;
  logic sync2;
  logic hist;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      hist  <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  assign pulse = sync2 & ~hist;

endmodule

// File: rtl/clock_ctrl.sv
// Digital-clock sequencer: one-second prescaler, set-mode FSM and registered
// enable pulses chaining the seconds, minutes and hour counters.
//
// state       | meaning
// ST_RUN      | timekeeping, enables driven by the tick and counter carries
// ST_SET_MIN  | time frozen, inc button steps minutes, blink active
// ST_SET_HOUR | time frozen, inc button steps hours, blink active
// ST_ILLEGAL  | unreachable code, returns to ST_RUN on the next cycle
module clock_ctrl
  import clock_ctrl_pkg::*;
#(
  parameter int TICK_DIV  = DEF_TICK_DIV,
  parameter int BLINK_DIV = DEF_BLINK_DIV
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       mode_btn,
  input  logic       inc_btn,
  input  logic       sec_cout,
  input  logic       min_cout,
  output logic       sec_en,
  output logic       min_en,
  output logic       hour_en,
  output logic [1:0] state,
  output logic       blink
);

  localparam int PW = cnt_width(TICK_DIV);
  localparam int BW = cnt_width(BLINK_DIV);
  localparam logic [PW-1:0] P_MAX = PW'(TICK_DIV - 1);
  localparam logic [BW-1:0] B_MAX = BW'(BLINK_DIV - 1);

  state_t        state_q;
  logic [PW-1:0] pcnt;
  logic [BW-1:0] bcnt;
  logic          mode_p;
  logic          inc_p;
  logic          tick;
  logic          in_run;
  logic          in_set;

  btn_pulse u_mode (
    .clk   (clk),
    .rstn  (rstn),
    .btn   (mode_btn),
    .pulse (mode_p)
  );

  btn_pulse u_inc (
    .clk   (clk),
    .rstn  (rstn),
    .btn   (inc_btn),
    .pulse (inc_p)
  );

  assign in_run = (state_q == ST_RUN);
  assign in_set = (state_q == ST_SET_MIN) || (state_q == ST_SET_HOUR);
  assign tick   = in_run && (pcnt == P_MAX);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_RUN;
      pcnt    <= '0;
      bcnt    <= '0;
      blink   <= 1'b0;
      sec_en  <= 1'b0;
      min_en  <= 1'b0;
      hour_en <= 1'b0;
    end else begin
      if (state_q == ST_ILLEGAL)
        state_q <= ST_RUN;
      else if (mode_p)
        state_q <= next_mode(state_q);

      // Leaving RUN parks the prescaler so re-entry waits a full second.
      if (in_run && !mode_p)
        pcnt <= tick ? '0 : pcnt + 1'b1;
      else
        pcnt <= '0;

      if (!in_set || mode_p) begin
        bcnt  <= '0;
        blink <= 1'b0;
      end else if (bcnt == B_MAX) begin
        bcnt  <= '0;
        blink <= ~blink;
      end else begin
        bcnt <= bcnt + 1'b1;
      end

      // A mode press in a set state swallows a coincident inc press.
      sec_en  <= tick;
      min_en  <= (tick && sec_cout) ||
                 ((state_q == ST_SET_MIN) && inc_p && !mode_p);
      hour_en <= (tick && sec_cout && min_cout) ||
                 ((state_q == ST_SET_HOUR) && inc_p && !mode_p);
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_clock_ctrl.sv
// Directed bench for clock_ctrl with TICK_DIV=4, BLINK_DIV=2 driving modelled
// BCD seconds/minutes counters and a 0..23 hour counter.
module tb_clock_ctrl;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       mode_btn = 1'b0;
  logic       inc_btn = 1'b0;
  logic       sec_cout;
  logic       min_cout;
  logic       sec_en;
  logic       min_en;
  logic       hour_en;
  logic [1:0] state;
  logic       blink;

  logic       ld = 1'b0;
  logic [7:0] ld_sec = 8'h00;
  logic [7:0] ld_min = 8'h00;
  logic [7:0] ld_hour = 8'h00;
  logic [7:0] sec = 8'h00;
  logic [7:0] mins = 8'h00;
  logic [7:0] hour = 8'h00;
  int         cnt_sec = 0;
  int         cnt_min = 0;
  int         cnt_hour = 0;

  int vectors = 0;
  int errs = 0;
  int n = 0;
  int c_sec, c_min, c_hour;

  clock_ctrl #(.TICK_DIV(4), .BLINK_DIV(2)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .mode_btn (mode_btn),
    .inc_btn  (inc_btn),
    .sec_cout (sec_cout),
    .min_cout (min_cout),
    .sec_en   (sec_en),
    .min_en   (min_en),
    .hour_en  (hour_en),
    .state    (state),
    .blink    (blink)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] bcd60(input logic [7:0] v);
    if (v == 8'h59)
      return 8'h00;
    else if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    else
      return v + 8'd1;
  endfunction

  assign sec_cout = (sec == 8'h59);
  assign min_cout = (mins == 8'h59);

  always @(posedge clk) begin
    if (ld) begin
      sec  <= ld_sec;
      mins <= ld_min;
      hour <= ld_hour;
    end else begin
      if (sec_en)  sec  <= bcd60(sec);
      if (min_en)  mins <= bcd60(mins);
      if (hour_en) hour <= (hour == 8'd23) ? 8'd0 : hour + 8'd1;
    end
    if (sec_en)  cnt_sec  <= cnt_sec + 1;
    if (min_en)  cnt_min  <= cnt_min + 1;
    if (hour_en) cnt_hour <= cnt_hour + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, exp, n);
    end
  endtask

  task automatic step();
    @(posedge clk);
    n++;
    @(negedge clk);
  endtask

  task automatic press(input bit is_mode);
    if (is_mode) mode_btn = 1'b1; else inc_btn = 1'b1;
    repeat (3) step();
    mode_btn = 1'b0;
    inc_btn  = 1'b0;
    repeat (3) step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_sec_en", sec_en, 1'b0);
    chk("rst_min_en", min_en, 1'b0);
    chk("rst_hour_en", hour_en, 1'b0);
    chk("rst_state", state, 2'd0);
    chk("rst_blink", blink, 1'b0);
    rstn = 1'b1;

    // Free-running RUN: sec_en after edges 4, 8, 12
    for (int i = 1; i <= 12; i++) begin
      step();
      chk("run_sec_en", sec_en, (n % 4 == 0));
      chk("run_min_en", min_en, 1'b0);
      chk("run_hour_en", hour_en, 1'b0);
    end
    chk("run_sec_val", sec, 8'h02);

    // Full carry chain from 59:59
    ld = 1'b1; ld_sec = 8'h59; ld_min = 8'h59; ld_hour = 8'd5;
    step();
    ld = 1'b0;
    step();
    chk("pre_sec_en", sec_en, 1'b0);
    step();
    step();
    chk("carry_sec_en", sec_en, 1'b1);
    chk("carry_min_en", min_en, 1'b1);
    chk("carry_hour_en", hour_en, 1'b1);
    step();
    chk("carry_sec_val", sec, 8'h00);
    chk("carry_min_val", mins, 8'h00);
    chk("carry_hour_val", hour, 8'd6);
    chk("carry_sec_en_off", sec_en, 1'b0);

    // Mode held 20 cycles; tick coincides with the mode pulse
    mode_btn = 1'b1;
    step();
    chk("mode_k_state", state, 2'd0);
    step();
    chk("mode_k1_state", state, 2'd0);
    step();
    chk("mode_k2_state", state, 2'd1);
    chk("mode_tick_sec_en", sec_en, 1'b1);
    for (int i = 0; i < 17; i++) begin
      step();
      chk("hold_state", state, 2'd1);
      chk("hold_sec_en", sec_en, 1'b0);
      chk("hold_blink", blink, ((n - 20) >> 1) & 1);
    end
    mode_btn = 1'b0;
    repeat (3) step();
    chk("hold_rel_state", state, 2'd1);
    chk("hold_sec_val", sec, 8'h01);

    // SET_MIN: three inc presses, first with exact latency
    c_sec = cnt_sec; c_min = cnt_min;
    inc_btn = 1'b1;
    step();
    chk("inc_k_min_en", min_en, 1'b0);
    step();
    chk("inc_k1_min_en", min_en, 1'b0);
    step();
    chk("inc_k2_min_en", min_en, 1'b1);
    inc_btn = 1'b0;
    step();
    chk("inc_k3_min_en", min_en, 1'b0);
    chk("inc_k3_min_val", mins, 8'h01);
    repeat (2) step();
    press(1'b0);
    press(1'b0);
    chk("setmin_pulses", cnt_min - c_min, 3);
    chk("setmin_val", mins, 8'h03);
    chk("setmin_no_sec", cnt_sec - c_sec, 0);

    // SET_HOUR: one inc press
    press(1'b1);
    chk("sethour_state", state, 2'd2);
    c_min = cnt_min; c_hour = cnt_hour;
    press(1'b0);
    chk("sethour_pulses", cnt_hour - c_hour, 1);
    chk("sethour_val", hour, 8'd7);
    chk("sethour_no_min", cnt_min - c_min, 0);

    // Back to RUN: first sec_en a full TICK_DIV after the prescaler restarts
    mode_btn = 1'b1;
    step();
    step();
    chk("torun_k1_state", state, 2'd2);
    step();
    chk("torun_k2_state", state, 2'd0);
    chk("torun_k2_sec_en", sec_en, 1'b0);
    mode_btn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("torun_wait_sec_en", sec_en, 1'b0);
    end
    step();
    chk("torun_first_sec_en", sec_en, 1'b1);
    step();
    chk("torun_after_sec_en", sec_en, 1'b0);

    // Mode and inc together in SET_MIN: mode wins, no enable
    press(1'b1);
    chk("sim_pre_state", state, 2'd1);
    c_min = cnt_min; c_hour = cnt_hour;
    mode_btn = 1'b1;
    inc_btn  = 1'b1;
    repeat (4) step();
    mode_btn = 1'b0;
    inc_btn  = 1'b0;
    repeat (3) step();
    chk("sim_state", state, 2'd2);
    chk("sim_no_min_en", cnt_min - c_min, 0);
    chk("sim_no_hour_en", cnt_hour - c_hour, 0);
    chk("sim_min_val", mins, 8'h03);

    // Asynchronous reset while blinking in SET_HOUR
    for (int i = 0; i < 8; i++) begin
      if (blink) break;
      step();
    end
    chk("blink_seen", blink, 1'b1);
    #2 rstn = 1'b0;
    #1;
    chk("arst_state", state, 2'd0);
    chk("arst_blink", blink, 1'b0);
    chk("arst_sec_en", sec_en, 1'b0);
    chk("arst_min_en", min_en, 1'b0);
    chk("arst_hour_en", hour_en, 1'b0);
    step();
    chk("arst_hold_state", state, 2'd0);
    rstn = 1'b1;
    repeat (2) step();
    chk("arst_rel_state", state, 2'd0);
    chk("arst_rel_blink", blink, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
